sys_pio_gen: RTL and testbench



---
 rtl/sys_pio_pkg.sv | 26 ++
 rtl/sys_pio_sync_edge.sv | 45 ++++
 rtl/sys_pio_gen.sv | 118 +++++++++++
 tb/tb_sys_pio_gen.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_pio_pkg.sv
// sys_pio_pkg: shared constants for the sys_pio_gen PIO slave.
// Register addresses, edge-mode encodings, readdata zero-extension.
package sys_pio_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // Force bits at and above w to zero.
  function automatic logic [31:0] rd_zext(
    input logic [31:0] v,
    input int unsigned w
  );
    logic [31:0] m;
    m = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return v & m;
  endfunction

endpackage

// File: rtl/sys_pio_sync_edge.sv
// sys_pio_sync_edge: input synchroniser, one-clock history, edge detect.
// Ports: clk, reset_n, in_port[WIDTH] -> in_sync[WIDTH], edge_det[WIDTH].
module sys_pio_sync_edge
  import sys_pio_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] in_sync,
  output logic [WIDTH-1:0] edge_det
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign in_sync = sync_q[SYNC_STAGES-1];

  generate
    if (EDGE_TYPE == EDGE_FALLING) begin : g_fall
      assign edge_det = ~in_sync & prev_q;
    end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
      assign edge_det = in_sync ^ prev_q;
    end else begin : g_rise
      assign edge_det = in_sync & ~prev_q;
    end
  endgenerate

endmodule

// File: rtl/sys_pio_gen.sv
// sys_pio_gen: Avalon-MM PIO, per-bit direction, set/clear, edge irq.
// Ports: clk, reset_n, address/chipselect/write_n/writedata/readdata
// slave bus, in_port, out_port, out_oe, irq.
module sys_pio_gen
  import sys_pio_pkg::*;
#(
  parameter int          WIDTH       = 32,
  parameter logic [31:0] RESET_VALUE = '0,
  parameter logic [31:0] RESET_DIR   = '0,
  parameter int          EDGE_TYPE   = EDGE_RISING,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] out_oe,
  output logic             irq
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_nxt;
  logic [WIDTH-1:0] dir_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] ecap_q;
  logic [WIDTH-1:0] ecap_clr;
  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] wd;
  logic [31:0]      rd32;
  logic             irq_q;
  logic             wr;
  logic             wr_data;
  logic             wr_dir;
  logic             wr_mask;
  logic             wr_ecap;
  logic             wr_set;
  logic             wr_clr;

  sys_pio_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_sync_edge (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_port  (in_port),
    .in_sync  (in_sync),
    .edge_det (edge_det)
  );

  assign wr = chipselect & ~write_n;
  assign wd = writedata[WIDTH-1:0];

  assign wr_data = wr && (address == ADDR_DATA);
  assign wr_dir  = wr && (address == ADDR_DIR);
  assign wr_mask = wr && (address == ADDR_IRQMASK);
  assign wr_ecap = wr && (address == ADDR_EDGECAP);
  assign wr_set  = wr && (address == ADDR_OUTSET);
  assign wr_clr  = wr && (address == ADDR_OUTCLR);

  // Set/clear touch only the addressed bits, so other
  // masters never race on a read-modify-write.
  always_comb begin
    data_nxt = data_q;
    unique case (1'b1)
      wr_data: data_nxt = wd;
      wr_set:  data_nxt = data_q | wd;
      wr_clr:  data_nxt = data_q & ~wd;
      default: data_nxt = data_q;
    endcase
  end

  assign ecap_clr = wr_ecap ? wd : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= RESET_VALUE[WIDTH-1:0];
      dir_q  <= RESET_DIR[WIDTH-1:0];
      mask_q <= '0;
      ecap_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      data_q <= data_nxt;
      if (wr_dir)
        dir_q <= wd;
      if (wr_mask)
        mask_q <= wd;
      // A new edge beats a same-cycle clear.
      ecap_q <= (ecap_q & ~ecap_clr) | edge_det;
      irq_q  <= |(ecap_q & mask_q);
    end
  end

  always_comb begin
    rd32 = '0;
    case (address)
      ADDR_DATA:
        rd32[WIDTH-1:0] = (data_q & dir_q)
                        | (in_sync & ~dir_q);
      ADDR_DIR:     rd32[WIDTH-1:0] = dir_q;
      ADDR_IRQMASK: rd32[WIDTH-1:0] = mask_q;
      ADDR_EDGECAP: rd32[WIDTH-1:0] = ecap_q;
      default:      rd32 = '0;
    endcase
  end

  assign readdata = rd_zext(rd32, WIDTH);
  assign out_port = data_q;
  assign out_oe   = dir_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_sys_pio_gen.sv
// tb_sys_pio_gen: scoreboard bench for sys_pio_gen, two instances
// (32-bit rising-edge, 8-bit any-edge).
module tb_sys_pio_gen;
  import sys_pio_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic        cs0 = 1'b0;
  logic        cs1 = 1'b0;
  logic [31:0] in0 = '0;
  logic [7:0]  in1 = '0;
  logic [31:0] rd0, out0, oe0;
  logic [31:0] rd1;
  logic [7:0]  out1, oe1;
  logic        irq0, irq1;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp, got;

  always #5 clk = ~clk;

  sys_pio_gen #(
    .WIDTH(32), .RESET_VALUE(32'hA5), .RESET_DIR(32'hFF),
    .EDGE_TYPE(EDGE_RISING), .SYNC_STAGES(2)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(cs0), .write_n(write_n), .writedata(writedata),
    .readdata(rd0), .in_port(in0), .out_port(out0),
    .out_oe(oe0), .irq(irq0)
  );

  sys_pio_gen #(
    .WIDTH(8), .RESET_VALUE(32'h0), .RESET_DIR(32'h0),
    .EDGE_TYPE(EDGE_ANY), .SYNC_STAGES(2)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(cs1), .write_n(write_n), .writedata(writedata),
    .readdata(rd1), .in_port(in1), .out_port(out1),
    .out_oe(oe1), .irq(irq1)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Write is sampled on the next rising edge.
  task automatic bus_write(input bit d, input logic [2:0] a,
                           input logic [31:0] v);
    address = a;
    writedata = v;
    write_n = 1'b0;
    cs0 = ~d;
    cs1 = d;
    tick(1);
    cs0 = 1'b0;
    cs1 = 1'b0;
    write_n = 1'b1;
  endtask

  task automatic peek(input bit d, input logic [2:0] a,
                      output logic [31:0] v);
    address = a;
    #1;
    v = d ? rd1 : rd0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
    exp_q.push_back(32'hA5);
    exp_q.push_back(32'hFF);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'hA5);
    exp_q.push_back(32'h0);
    got = out0; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++;
      $display("FAIL reset_out_port got %h want %h", got, exp); end
    got = oe0; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++;
      $display("FAIL reset_out_oe got %h want %h", got, exp); end
    got = {31'b0, irq0}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++;
      $display("FAIL reset_irq got %h want %h", got, exp); end
    peek(0, ADDR_DATA, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++;
      $display("FAIL reset_rd_data got %h want %h", got, exp); end
    got = {24'b0, out1}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++;
      $display("FAIL reset_out_port_w8 got %h want %h", got, exp); end
  endtask

  task automatic test_set_clr;
    logic [2:0]  ta [3] = '{ADDR_DATA, ADDR_OUTSET, ADDR_OUTCLR};
    logic [31:0] tv [3] = '{32'h0F0F0000, 32'h000000F0,
                            32'h0F000000};
    logic [31:0] te [3] = '{32'h0F0F0000, 32'h0F0F00F0,
                            32'h000F00F0};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(out0);
      exp_q.push_back(te[i]);
      got = out0; exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++;
        $display("FAIL setclr_hold%0d got %h want %h", i, got, exp); end
      bus_write(0, ta[i], tv[i]);
      got = out0; exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++;
        $display("FAIL setclr_out%0d got %h want %h", i, got, exp); end
    end
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h000000F0);
    peek(0, ADDR_OUTSET, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++;
      $display("FAIL rd_outset got %h want %h", got, exp); end
    peek(0, ADDR_OUTCLR, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++;
      $display("FAIL rd_outclr got %h want %h", got, exp); end
    peek(0, ADDR_DATA, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++;
      $display("FAIL rd_data_mixed got %h want %h", got, exp); end
  endtask

  task automatic test_edge_irq;
    bus_write(0, ADDR_DIR, 32'h0);
    bus_write(0, ADDR_IRQMASK, 32'h1);
    in0[0] = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h1);
    tick(1);
    peek(0, ADDR_DATA, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++;
      $display("FAIL sync_lat1 got %h want %h", got, exp); end
    tick(1);
    peek(0, ADDR_DATA, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++;
      $display("FAIL sync_lat2 got %h want %h", got, exp); end
    peek(0, ADDR_EDGECAP, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++;
      $display("FAIL ecap_early got %h want %h", got, exp); end
    tick(1);
    in0[0] = 1'b0;
    peek(0, ADDR_EDGECAP, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++;
      $display("FAIL ecap_set got %h want %h", got, exp); end
    got = {31'b0, irq0}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++;
      $display("FAIL irq_early got %h want %h", got, exp); end
    tick(1);
    got = {31'b0, irq0}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++;
      $display("FAIL irq_set got %h want %h", got, exp); end
    tick(3);
    bus_write(0, ADDR_EDGECAP, 32'h1);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    peek(0, ADDR_EDGECAP, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++;
      $display("FAIL ecap_clr got %h want %h", got, exp); end
    tick(1);
    got = {31'b0, irq0}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++;
      $display("FAIL irq_clr got %h want %h", got, exp); end
  endtask

  task automatic test_clr_vs_edge;
    bus_write(0, ADDR_IRQMASK, 32'h8);
    in0[3] = 1'b1;
    tick(4);
    in0[3] = 1'b0;
    tick(4);
    exp_q.push_back(32'h8);
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h8);
    exp_q.push_back(32'h1);
    peek(0, ADDR_EDGECAP, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++;
      $display("FAIL race_pre got %h want %h", got, exp); end
    got = {31'b0, irq0}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++;
      $display("FAIL race_pre_irq got %h want %h", got, exp); end
    in0[3] = 1'b1;
    tick(2);
    bus_write(0, ADDR_EDGECAP, 32'h8);
    tick(1);
    peek(0, ADDR_EDGECAP, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++;
      $display("FAIL race_ecap got %h want %h", got, exp); end
    got = {31'b0, irq0}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++;
      $display("FAIL race_irq got %h want %h", got, exp); end
  endtask

  task automatic test_width8;
    bus_write(1, ADDR_DATA, 32'hFFFFFFFF);
    bus_write(1, ADDR_DIR, 32'hFFFFFFFF);
    exp_q.push_back(32'hFF);
    exp_q.push_back(32'hFF);
    exp_q.push_back(32'h000000FF);
    exp_q.push_back(32'h000000FF);
    got = {24'b0, out1}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++;
      $display("FAIL w8_out got %h want %h", got, exp); end
    got = {24'b0, oe1}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++;
      $display("FAIL w8_oe got %h want %h", got, exp); end
    peek(1, ADDR_DATA, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++;
      $display("FAIL w8_rd_data got %h want %h", got, exp); end
    peek(1, ADDR_DIR, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++;
      $display("FAIL w8_rd_dir got %h want %h", got, exp); end
    bus_write(1, 3'd6, 32'h12345600);
    bus_write(1, 3'd7, 32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'hFF);
    exp_q.push_back(32'hFF);
    exp_q.push_back(32'h0);
    peek(1, 3'd6, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++;
      $display("FAIL w8_rd_a6 got %h want %h", got, exp); end
    got = {24'b0, out1}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++;
      $display("FAIL w8_a6_out got %h want %h", got, exp); end
    got = {24'b0, oe1}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++;
      $display("FAIL w8_a6_oe got %h want %h", got, exp); end
    peek(1, ADDR_IRQMASK, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++;
      $display("FAIL w8_a6_mask got %h want %h", got, exp); end
  endtask

  task automatic test_any_edge_reset;
    bus_write(1, ADDR_IRQMASK, 32'h2);
    for (int i = 0; i < 2; i++) begin
      in1[1] = ~in1[1];
      exp_q.push_back(32'h2);
      exp_q.push_back(32'h1);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      tick(4);
      peek(1, ADDR_EDGECAP, got); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++;
        $display("FAIL any_cap%0d got %h want %h", i, got, exp); end
      got = {31'b0, irq1}; exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++;
        $display("FAIL any_irq%0d got %h want %h", i, got, exp); end
      bus_write(1, ADDR_EDGECAP, 32'h2);
      tick(1);
      peek(1, ADDR_EDGECAP, got); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++;
        $display("FAIL any_clr%0d got %h want %h", i, got, exp); end
      got = {31'b0, irq1}; exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++;
        $display("FAIL any_irqclr%0d got %h want %h", i, got, exp); end
    end
    in1[1] = 1'b1;
    tick(4);
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    got = {31'b0, irq1}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++;
      $display("FAIL rst_pre_irq got %h want %h", got, exp); end
    #3;
    reset_n = 1'b0;
    #1;
    peek(1, ADDR_EDGECAP, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++;
      $display("FAIL rst_async_ecap got %h want %h", got, exp); end
    got = {31'b0, irq1}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++;
      $display("FAIL rst_async_irq got %h want %h", got, exp); end
    got = {24'b0, out1}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++;
      $display("FAIL rst_async_out got %h want %h", got, exp); end
    in0 = '0;
    in1 = '0;
    tick(2);
    reset_n = 1'b1;
    tick(5);
    exp_q.push_back(32'h0);
    peek(1, ADDR_EDGECAP, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++;
      $display("FAIL rst_lost_cap got %h want %h", got, exp); end
  endtask

  initial begin
    test_reset();
    test_set_clr();
    test_edge_irq();
    test_clr_vs_edge();
    test_width8();
    test_any_edge_reset();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
